// File: rtl/datapath_pkg.sv
// Shared types, ALU codes and R-type decode for the datapath sequencer.
package datapath_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXECUTE,
        WRITEBACK
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic       legal;
        logic [2:0] alu;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d.legal = 1'b0;
        d.alu   = ALU_AND;
        if (ir[6:0] == OPC_RTYPE) begin
            case ({ir[31:25], ir[14:12]})
                {FUNCT7_BASE, 3'b000}: begin d.legal = 1'b1; d.alu = ALU_ADD; end
                {FUNCT7_ALT,  3'b000}: begin d.legal = 1'b1; d.alu = ALU_SUB; end
                {FUNCT7_BASE, 3'b111}: begin d.legal = 1'b1; d.alu = ALU_AND; end
                {FUNCT7_BASE, 3'b110}: begin d.legal = 1'b1; d.alu = ALU_OR;  end
                {FUNCT7_BASE, 3'b010}: begin d.legal = 1'b1; d.alu = ALU_SLT; end
                default: begin
                    d.legal = 1'b0;
                    d.alu   = ALU_AND;
                end
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Pointer-based instruction FIFO; the extra pointer bit separates full from empty.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller: buffers R-type instructions, drives the register
// block + ALU through DECODE/EXECUTE/WRITEBACK and reports retirement.
module datapath_sequencer #(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [4:0]      read_reg1,
    output logic [4:0]      read_reg2,
    output logic [4:0]      write_reg,
    output logic [2:0]      alu_control,
    output logic            write_on_register,
    input  logic            zero_flag,
    output logic            busy,
    output logic            retire_valid,
    output logic            retire_zero,
    output logic            retire_illegal
);

    import datapath_pkg::*;

    state_t          state;
    state_t          state_nx;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] fifo_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            active;
    dec_t            dec;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (instr_valid),
        .pop      (pop),
        .data_in  (instr),
        .data_out (fifo_q),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign instr_ready = !fifo_full;
    assign dec         = decode(ir[31:0]);
    assign active      = (state != IDLE);
    assign busy        = active || !fifo_empty;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                if (dec.legal) begin
                    state_nx = EXECUTE;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = DECODE;
                end else begin
                    state_nx = IDLE;
                end
            end
            EXECUTE: state_nx = WRITEBACK;
            WRITEBACK: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = DECODE;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            ir             <= '0;
            retire_valid   <= 1'b0;
            retire_zero    <= 1'b0;
            retire_illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if (pop) ir <= fifo_q;
            // Illegal words retire straight out of DECODE, never seeing zero_flag.
            retire_valid   <= (state == WRITEBACK) ||
                              (state == DECODE && !dec.legal);
            retire_zero    <= (state == WRITEBACK) && zero_flag;
            retire_illegal <= (state == DECODE) && !dec.legal;
        end
    end

    assign read_reg1 = active ? ir[19:15] : 5'd0;
    assign read_reg2 = active ? ir[24:20] : 5'd0;
    assign write_reg = active ? ir[11:7]  : 5'd0;

    assign alu_control = (state == EXECUTE || state == WRITEBACK) ?
                         dec.alu : ALU_AND;

    assign write_on_register = (state == WRITEBACK) && dec.legal &&
                               (ir[11:7] != 5'd0);

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: directed R-type vectors,
// expectations queued at acceptance and checked by a negedge monitor.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        instr_valid = 1'b0;
    logic        zero_flag = 1'b0;
    logic        instr_ready;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [2:0]  alu_control;
    logic        write_on_register;
    logic        busy;
    logic        retire_valid;
    logic        retire_zero;
    logic        retire_illegal;

    datapath_sequencer #(
        .FIFO_DEPTH (2),
        .XLEN       (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .instr             (instr),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .read_reg1         (read_reg1),
        .read_reg2         (read_reg2),
        .write_reg         (write_reg),
        .alu_control       (alu_control),
        .write_on_register (write_on_register),
        .zero_flag         (zero_flag),
        .busy              (busy),
        .retire_valid      (retire_valid),
        .retire_zero       (retire_zero),
        .retire_illegal    (retire_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   acc;
        int   lat;
        logic zero;
        logic illegal;
    } ret_t;

    typedef struct {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] alu;
    } wr_t;

    ret_t rq[$];
    wr_t  wq[$];
    ret_t r;
    wr_t  w;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int writes = 0;
    int retires = 0;
    int stalls = 0;
    int last_ret = -1;
    bit gap_mode = 1'b0;
    int w0;
    int r0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every write and every retire pulse must match a queued entry.
    initial forever begin
        @(negedge clk);
        if (write_on_register) begin
            writes++;
            if (wq.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                w = wq.pop_front();
                check("wb_write_reg", {27'd0, write_reg}, {27'd0, w.rd});
                check("wb_read_reg1", {27'd0, read_reg1}, {27'd0, w.rs1});
                check("wb_read_reg2", {27'd0, read_reg2}, {27'd0, w.rs2});
                check("wb_alu", {29'd0, alu_control}, {29'd0, w.alu});
            end
        end
        if (retire_valid) begin
            retires++;
            if (rq.size() == 0) begin
                check("unexpected_retire", 32'd1, 32'd0);
            end else begin
                r = rq.pop_front();
                check("retire_zero", {31'd0, retire_zero}, {31'd0, r.zero});
                check("retire_illegal", {31'd0, retire_illegal},
                      {31'd0, r.illegal});
                if (r.lat >= 0)
                    check("retire_latency", cyc, r.acc + r.lat);
            end
            if (gap_mode && last_ret >= 0)
                check("retire_gap", cyc - last_ret, 32'd3);
            last_ret = cyc;
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [31:0] word, input int lat,
                        input logic z, input logic ill, input bit wr,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] alu);
        instr       = word;
        instr_valid = 1'b1;
        for (int t = 0; t < 40 && !instr_ready; t++) begin
            stalls++;
            @(negedge clk);
        end
        if (!instr_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            rq.push_back('{cyc + 1, lat, z, ill});
            if (wr) wq.push_back('{rd, rs1, rs2, alu});
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 60 && (busy || rq.size() != 0); t++)
            @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain_retire_q", rq.size(), 32'd0);
        check("drain_write_q", wq.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_regs", {17'd0, read_reg1, read_reg2, write_reg}, 32'd0);
        check("rst_alu_wr", {28'd0, alu_control, write_on_register}, 32'd0);
        check("rst_retire", {29'd0, retire_valid, retire_zero,
              retire_illegal}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // ADD x3,x1,x2: full latency walk
        send(32'h002081B3, 4, 1'b0, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 3'b010);
        instr_valid = 1'b0;
        check("t1_ready", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        check("t1_dec_rs1", {27'd0, read_reg1}, 32'd1);
        check("t1_dec_rs2", {27'd0, read_reg2}, 32'd2);
        check("t1_dec_rd", {27'd0, write_reg}, 32'd3);
        check("t1_dec_alu", {29'd0, alu_control}, 32'd0);
        @(negedge clk);
        check("t1_exe_alu", {29'd0, alu_control}, 32'h2);
        check("t1_exe_wr", {31'd0, write_on_register}, 32'd0);
        wait_idle();

        // SUB x5,x1,x2 with zero_flag high
        zero_flag = 1'b1;
        send(32'h402082B3, 4, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 5'd2, 3'b110);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t2_exe_alu", {29'd0, alu_control}, 32'h6);
        wait_idle();
        zero_flag = 1'b0;

        // ADD x0,x1,x2: retires without a write
        w0 = writes;
        r0 = retires;
        send(32'h00208033, 4, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 3'b010);
        instr_valid = 1'b0;
        wait_idle();
        check("t3_no_write", writes, w0);
        check("t3_retired", retires, r0 + 1);

        // Illegal ADDI word; zero_flag high must not leak into retire_zero
        zero_flag = 1'b1;
        w0 = writes;
        send(32'h00000013, 2, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
        instr_valid = 1'b0;
        @(negedge clk);
        check("t4_dec_alu", {29'd0, alu_control}, 32'd0);
        @(negedge clk);
        check("t4_no_execute", {31'd0, busy}, 32'd0);
        check("t4_retire", {30'd0, retire_valid, retire_illegal}, 32'h3);
        wait_idle();
        check("t4_no_write", writes, w0);
        zero_flag = 1'b0;

        // Five back-to-back ADDs into a 2-deep FIFO
        gap_mode = 1'b1;
        last_ret = -1;
        stalls   = 0;
        r0       = retires;
        for (int i = 0; i < 5; i++) begin
            send({7'd0, 5'(i + 2), 5'(i + 1), 3'b000, 5'(i + 10), 7'b0110011},
                 (i == 0) ? 4 : -1, 1'b0, 1'b0, 1'b1,
                 5'(i + 10), 5'(i + 1), 5'(i + 2), 3'b010);
        end
        instr_valid = 1'b0;
        check("t5_ready_dropped", {31'd0, stalls > 0}, 32'd1);
        wait_idle();
        check("t5_retired", retires, r0 + 5);
        gap_mode = 1'b0;

        // Reset while the first of three is in EXECUTE, two still queued
        for (int i = 0; i < 3; i++) begin
            send({7'd0, 5'd2, 5'd1, 3'b000, 5'(i + 20), 7'b0110011},
                 -1, 1'b0, 1'b0, 1'b1, 5'(i + 20), 5'd1, 5'd2, 3'b010);
        end
        instr_valid = 1'b0;
        check("t6_pre_alu", {29'd0, alu_control}, 32'h2);
        check("t6_pre_full", {31'd0, instr_ready}, 32'd0);
        #1;
        reset = 1'b0;
        rq.delete();
        wq.delete();
        w0 = writes;
        r0 = retires;
        #1;
        check("t6_rst_regs", {17'd0, read_reg1, read_reg2, write_reg}, 32'd0);
        check("t6_rst_alu_wr", {28'd0, alu_control, write_on_register},
              32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("t6_rst_retire", {31'd0, retire_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_post_busy", {31'd0, busy}, 32'd0);
        check("t6_post_retires", retires, r0);
        check("t6_post_writes", writes, w0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
